// File: rtl/accel_pkg.sv
// Shared definitions for the processing-unit array and its downstream
// result path.
//
// Contents:
//   NUM_PROCESSING_UNITS, VECTOR_SIZE, DATA_WIDTH : array geometry defaults
//   vector_data_t   : one unit's result vector, element 0 in the low bits
//   collect_state_e : result_collector control states
//   result_beat_t   : one serialised stream element as seen downstream
package accel_pkg;

  localparam int NUM_PROCESSING_UNITS = 4;
  localparam int VECTOR_SIZE          = 16;
  localparam int DATA_WIDTH           = 32;

  typedef logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] vector_data_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } collect_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]                   data;
    logic [$clog2(NUM_PROCESSING_UNITS)-1:0] unit;
    logic [$clog2(VECTOR_SIZE)-1:0]          elem;
    logic                                    last;
  } result_beat_t;

endpackage

// File: rtl/result_buffer.sv
// Per-unit result storage for result_collector.
//
// Holds one result vector per processing unit plus the mask of units whose
// result has been captured in the current job. Capture decisions (including
// the overrun filter) are made by the parent; this block just stores.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (clears the mask only)
//   clear        : clears the captured mask at the start of a job
//   capture_en   : per-unit write strobe, one bit per unit
//   unit_data    : per-unit result vectors, written where capture_en is set
//   rd_unit      : read port unit index
//   rd_elem      : read port element index
//   captured     : per-unit captured mask
//   rd_data      : stored element at (rd_unit, rd_elem)
//   rd_captured  : captured flag of rd_unit
module result_buffer
  import accel_pkg::*;
#(
  parameter int NUM_UNITS  = NUM_PROCESSING_UNITS,
  parameter int VEC_LEN    = VECTOR_SIZE,
  parameter int DATA_WIDTH = accel_pkg::DATA_WIDTH,
  localparam int UIW = $clog2(NUM_UNITS),
  localparam int EIW = $clog2(VEC_LEN)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic [NUM_UNITS-1:0]              capture_en,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] unit_data [NUM_UNITS],
  input  logic [UIW-1:0]                    rd_unit,
  input  logic [EIW-1:0]                    rd_elem,
  output logic [NUM_UNITS-1:0]              captured,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_captured
);

  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] buffer [NUM_UNITS];

  // Captured mask: reset and job start both empty it; otherwise it only
  // accumulates, so a unit stays captured until the next job.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      captured <= '0;
    end else if (clear) begin
      captured <= '0;
    end else begin
      captured <= captured | capture_en;
    end
  end

  // Vector storage has no reset; the mask alone says which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (capture_en[i]) begin
        buffer[i] <= unit_data[i];
      end
    end
  end

  assign rd_data     = buffer[rd_unit][rd_elem];
  assign rd_captured = captured[rd_unit];

endmodule

// File: rtl/result_collector.sv
// Result collector: captures each processing unit's result vector when it
// signals done and serialises all results, unit by unit and element by
// element, onto one element-wide valid/ready stream.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : pulse arming a new job (ignored while busy)
//   unit_done   : per-unit done strobes
//   unit_data   : per-unit result vectors (vector_data_t layout)
//   out_valid, out_ready : stream handshake
//   out_data, out_unit, out_elem, out_last : stream payload
//   busy        : job in progress
//   job_done    : one-cycle pulse after the final beat is accepted
//   overrun     : sticky flag, a unit reported done twice in one job
module result_collector
  import accel_pkg::*;
#(
  parameter int NUM_UNITS  = NUM_PROCESSING_UNITS,
  parameter int VEC_LEN    = VECTOR_SIZE,
  parameter int DATA_WIDTH = accel_pkg::DATA_WIDTH,
  localparam int UIW = $clog2(NUM_UNITS),
  localparam int EIW = $clog2(VEC_LEN)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NUM_UNITS-1:0]              unit_done,
  input  logic [VEC_LEN-1:0][DATA_WIDTH-1:0] unit_data [NUM_UNITS],
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [UIW-1:0]                    out_unit,
  output logic [EIW-1:0]                    out_elem,
  output logic                              out_last,
  output logic                              busy,
  output logic                              job_done,
  output logic                              overrun
);

  collect_state_e       state_q, state_d;
  logic [UIW-1:0]       unit_idx_q, unit_idx_d;
  logic [EIW-1:0]       elem_idx_q, elem_idx_d;
  logic                 overrun_q, overrun_d;
  logic                 job_done_q, job_done_d;
  logic [NUM_UNITS-1:0] captured;
  logic [NUM_UNITS-1:0] capture_en;
  logic                 buf_clear;
  logic                 head_captured;
  logic                 last_pos;
  logic [DATA_WIDTH-1:0] head_data;

  result_buffer #(
    .NUM_UNITS (NUM_UNITS),
    .VEC_LEN   (VEC_LEN),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (buf_clear),
    .capture_en (capture_en),
    .unit_data  (unit_data),
    .rd_unit    (unit_idx_q),
    .rd_elem    (elem_idx_q),
    .captured   (captured),
    .rd_data    (head_data),
    .rd_captured(head_captured)
  );

  // Control registers: state, stream read position, sticky overrun and the
  // job_done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      unit_idx_q <= '0;
      elem_idx_q <= '0;
      overrun_q  <= 1'b0;
      job_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_idx_q <= unit_idx_d;
      elem_idx_q <= elem_idx_d;
      overrun_q  <= overrun_d;
      job_done_q <= job_done_d;
    end
  end

  // Next-state logic. Capture and streaming are independent: a late unit
  // may be captured while an earlier one streams, and a unit captured ahead
  // of its turn simply waits in its buffer. The read position is returned
  // to zero after the final beat so an idle collector reports unit/elem 0.
  always_comb begin
    state_d    = state_q;
    unit_idx_d = unit_idx_q;
    elem_idx_d = elem_idx_q;
    overrun_d  = overrun_q;
    job_done_d = 1'b0;
    buf_clear  = 1'b0;
    capture_en = '0;
    out_valid  = 1'b0;
    last_pos   = (unit_idx_q == UIW'(NUM_UNITS - 1)) &&
                 (elem_idx_q == EIW'(VEC_LEN - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = STREAM;
          unit_idx_d = '0;
          elem_idx_d = '0;
          overrun_d  = 1'b0;
          buf_clear  = 1'b1;
        end
      end
      STREAM: begin
        // A repeat done from an already captured unit is dropped and only
        // flagged, so the first result always wins.
        capture_en = unit_done & ~captured;
        if (|(unit_done & captured)) begin
          overrun_d = 1'b1;
        end
        out_valid = head_captured;
        if (head_captured && out_ready) begin
          if (last_pos) begin
            state_d    = IDLE;
            unit_idx_d = '0;
            elem_idx_d = '0;
            job_done_d = 1'b1;
          end else if (elem_idx_q == EIW'(VEC_LEN - 1)) begin
            elem_idx_d = '0;
            unit_idx_d = unit_idx_q + UIW'(1);
          end else begin
            elem_idx_d = elem_idx_q + EIW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload is forced to zero while not valid so the unreset buffer
  // contents never leak onto the bus.
  assign out_data = out_valid ? head_data : '0;
  assign out_unit = unit_idx_q;
  assign out_elem = elem_idx_q;
  assign out_last = last_pos;
  assign busy     = (state_q == STREAM);
  assign job_done = job_done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector. A behavioural model tracks the
// job as a linear beat position 0..63 and the first captured vector of each
// unit; the DUT outputs are compared against it every cycle.
module tb_result_collector;
  import accel_pkg::*;

  localparam int NU    = 4;
  localparam int VL    = 16;
  localparam int DW    = 32;
  localparam int TOTAL = NU * VL;
  localparam int LIMIT = 3000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [NU-1:0]         unit_done;
  logic [VL-1:0][DW-1:0] unit_data [NU];
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic [1:0]            out_unit;
  logic [3:0]            out_elem;
  logic                  out_last;
  logic                  busy;
  logic                  job_done;
  logic                  overrun;

  result_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .unit_done(unit_done),
    .unit_data(unit_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_unit (out_unit),
    .out_elem (out_elem),
    .out_last (out_last),
    .busy     (busy),
    .job_done (job_done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit            m_busy;
  bit            m_cap [NU];
  bit            m_overrun;
  bit            m_job_done;
  bit            m_fresh_reset;
  int            m_pos;
  logic [DW-1:0] m_vec [NU][VL];

  logic [DW-1:0] stim [NU][VL];
  int            beats_seen;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               tag, actual, expected, $time);
    end
  endtask

  task automatic compareAll();
    int u, e;
    bit exp_valid;
    u = m_pos / VL;
    e = m_pos % VL;
    exp_valid = m_busy && m_cap[u];
    checkOutput("busy",      64'(busy),      64'(m_busy));
    checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
    checkOutput("job_done",  64'(job_done),  64'(m_job_done));
    checkOutput("overrun",   64'(overrun),   64'(m_overrun));
    checkOutput("out_unit",  64'(out_unit),  64'(u));
    checkOutput("out_elem",  64'(out_elem),  64'(e));
    checkOutput("out_last",  64'(out_last),  64'(m_pos == TOTAL - 1));
    if (exp_valid)
      checkOutput("out_data", 64'(out_data), 64'(m_vec[u][e]));
    else if (m_fresh_reset)
      checkOutput("out_data_reset", 64'(out_data), 64'(0));
  endtask

  // One clock: compare outputs at the falling edge, drive the next inputs,
  // then advance the model as the coming rising edge will.
  task automatic applyStimulus(input bit st, input logic [NU-1:0] done,
                               input bit rdy, input bit rn);
    bit hs;
    @(negedge clk);
    compareAll();
    if (out_valid && rdy) beats_seen++;
    start     = st;
    unit_done = done;
    out_ready = rdy;
    rst_n     = rn;
    for (int u = 0; u < NU; u++)
      for (int e = 0; e < VL; e++)
        unit_data[u][e] = stim[u][e];

    m_fresh_reset = 1'b0;
    if (!rn) begin
      m_busy = 0; m_pos = 0; m_overrun = 0; m_job_done = 0;
      m_fresh_reset = 1'b1;
      for (int u = 0; u < NU; u++) m_cap[u] = 0;
    end else begin
      m_job_done = 0;
      if (m_busy) begin
        hs = m_cap[m_pos / VL] && rdy;
        for (int u = 0; u < NU; u++) begin
          if (done[u]) begin
            if (m_cap[u]) m_overrun = 1;
            else begin
              m_cap[u] = 1;
              for (int e = 0; e < VL; e++) m_vec[u][e] = stim[u][e];
            end
          end
        end
        if (hs) begin
          if (m_pos == TOTAL - 1) begin
            m_busy = 0; m_pos = 0; m_job_done = 1;
          end else begin
            m_pos++;
          end
        end
      end else if (st) begin
        m_busy = 1; m_pos = 0; m_overrun = 0;
        for (int u = 0; u < NU; u++) m_cap[u] = 0;
      end
    end
  endtask

  // arr[u]: cycle after start at which unit u reports done.
  // dup_unit/dup_cycle: a second done (new data) for one unit, or -1.
  // mid_start: cycle to pulse start mid-job, or -1.
  // start_on_last: pulse start together with the final beat.
  // abort_beat: pull reset once this many beats were accepted, or -1.
  task automatic runJob(input int arr [NU], input int ready_pct,
                        input int dup_unit, input int dup_cycle,
                        input int mid_start, input bit start_on_last,
                        input int abort_beat, input bit seq_data);
    logic [NU-1:0] done;
    bit st, rdy, rn, aborted;
    int cyc;
    for (int u = 0; u < NU; u++)
      for (int e = 0; e < VL; e++)
        stim[u][e] = seq_data ? DW'(u * VL + e) : DW'($urandom);
    beats_seen = 0;
    aborted    = 0;
    applyStimulus(1'b1, '0, 1'b1, 1'b1);
    cyc = 0;
    while (m_busy && cyc < LIMIT) begin
      done = '0;
      for (int u = 0; u < NU; u++)
        if (cyc == arr[u]) done[u] = 1'b1;
      if (dup_unit >= 0 && cyc == dup_cycle) begin
        done[dup_unit] = 1'b1;
        for (int e = 0; e < VL; e++) stim[dup_unit][e] = DW'($urandom);
      end
      rdy = ($urandom_range(0, 99) < ready_pct);
      st  = (cyc == mid_start);
      if (start_on_last && m_pos == TOTAL - 1) begin
        st  = 1'b1;
        rdy = 1'b1;
      end
      rn = !(abort_beat >= 0 && m_pos == abort_beat);
      if (!rn) aborted = 1;
      applyStimulus(st, done, rdy, rn);
      cyc++;
    end
    checkOutput("job_timeout", 64'(cyc >= LIMIT), 64'(0));
    if (!aborted) checkOutput("beat_count", 64'(beats_seen), 64'(TOTAL));
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    int arr [NU];
    rst_n = 0; start = 0; unit_done = '0; out_ready = 0;
    for (int u = 0; u < NU; u++)
      for (int e = 0; e < VL; e++) begin
        stim[u][e] = '0;
        unit_data[u][e] = '0;
      end
    for (int u = 0; u < NU; u++) m_cap[u] = 0;
    m_busy = 0; m_pos = 0; m_overrun = 0; m_job_done = 0; m_fresh_reset = 1;
    beats_seen = 0;
    repeat (2) @(posedge clk);

    // unit_done while idle must be ignored
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, NU'($urandom), 1'b1, 1'b1);

    $display("[TB] in-order completion");
    arr = '{0, 1, 2, 3};
    runJob(arr, 100, -1, 0, -1, 1'b0, -1, 1'b1);

    $display("[TB] reverse completion");
    arr = '{30, 20, 10, 0};
    runJob(arr, 100, -1, 0, -1, 1'b0, -1, 1'b0);

    $display("[TB] random backpressure");
    for (int u = 0; u < NU; u++) arr[u] = $urandom_range(0, 40);
    runJob(arr, 50, -1, 0, -1, 1'b0, -1, 1'b0);

    $display("[TB] overrun on unit 2");
    arr = '{25, 2, 4, 6};
    runJob(arr, 100, 2, 12, -1, 1'b0, -1, 1'b0);

    $display("[TB] start mid-job and on last beat");
    arr = '{0, 3, 6, 9};
    runJob(arr, 70, -1, 0, 20, 1'b1, -1, 1'b0);

    $display("[TB] reset after beat 20");
    arr = '{0, 0, 0, 0};
    runJob(arr, 100, -1, 0, -1, 1'b0, 20, 1'b0);

    $display("[TB] fresh jobs after reset");
    for (int j = 0; j < 3; j++) begin
      for (int u = 0; u < NU; u++) arr[u] = $urandom_range(0, 60);
      runJob(arr, $urandom_range(30, 100), -1, 0, -1, 1'b0, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
